// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the decode-stage register file.
// Imported by the storage top and the scoreboard.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int AW_DEF = clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits plus a sticky flag for
// writebacks that land on a register nobody reserved.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  parameter int AW    = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_eff_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_eff_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              wb_err_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff_i[j]) begin
        if (!busy_q[wr_addr_i[j*AW +: AW]]) err_d = 1'b1;
        busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    // A fresh producer outranks a retiring one
    if (iss_eff_i) busy_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_o   = busy_q;
  assign wb_err_o = err_q;

endmodule

// File: rtl/rf_bypass_sb.sv
// Multi-port integer register file with write-first bypass
// and RAW scoreboard for the decode stage.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wb_err
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [AW-1:0]      waddr [NWR];
  logic [XLEN-1:0]    wdata [NWR];
  logic [NWR-1:0]     wr_eff;
  logic               iss_eff;
  logic [NREGS*XLEN-1:0] mem;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      waddr[j]  = wr_addr[j*AW +: AW];
      wdata[j]  = wr_data[j*XLEN +: XLEN];
      wr_eff[j] = wr_en[j] & ~stall & ~(ZR & (waddr[j] == '0));
    end
  end

  assign iss_eff = iss_en & ~stall & ~(ZR & (iss_addr == '0));

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (ZR && r == 0) begin : g_zero
      assign mem[r*XLEN +: XLEN] = '0;
    end else begin : g_ff
      logic [XLEN-1:0] entry_q, entry_d;
      logic            we;
      // Later ports override earlier ones on an address clash
      always_comb begin
        we      = 1'b0;
        entry_d = entry_q;
        for (int j = 0; j < NWR; j++) begin
          if (wr_eff[j] && waddr[j] == AW'(r)) begin
            we      = 1'b1;
            entry_d = wdata[j];
          end
        end
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset)   entry_q <= '0;
        else if (we) entry_q <= entry_d;
      end
      assign mem[r*XLEN +: XLEN] = entry_q;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] d;
      logic            hit;
      ra  = rd_addr[i*AW +: AW];
      d   = mem[int'(ra)*XLEN +: XLEN];
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_eff[j] && waddr[j] == ra) begin
          hit = 1'b1;
          d   = wdata[j];
        end
      end
      if (ZR && ra == '0) d = '0;
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i] = busy_vec[ra] & ~hit;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .wr_eff_i   (wr_eff),
    .wr_addr_i  (wr_addr),
    .iss_eff_i  (iss_eff),
    .iss_addr_i (iss_addr),
    .busy_o     (busy_vec),
    .wb_err_o   (wb_err)
  );

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Scoreboard-driven bench: stimulus queues expectations,
// a monitor drains and compares them.
module tb_rf_bypass_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                stall;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREGS-1:0]    busy_vec;
  logic                wb_err;

  rf_bypass_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
    .NWR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_run = 0;
  int   n_fail = 0;
  event chk_now;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return rd_data[31:0];
      1: return rd_data[63:32];
      2: return {31'b0, rd_busy[0]};
      3: return busy_vec;
      4: return {31'b0, wb_err};
      default: return {31'b0, rd_busy[1]};
    endcase
  endfunction

  always begin
    @(negedge clk or chk_now);
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = exp_q.pop_front();
      got = observe(e.sel);
      n_run++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic chk(input string n, input int sel, input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.sel  = sel;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    stall    = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    rd_addr  = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    cyc();
    wr(0, 5, 32'hDEADBEEF); iss(6);
    chk("rst_busy", 3, 32'h0);
    chk("rst_err", 4, 32'h0);
    chk("rst_rd0", 0, 32'h0);
    chk("rst_rbusy", 2, 32'h0);
    cyc();
    reset = 1'b0;
    chk("rst_disc", 3, 32'h0);

    cyc(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    chk("r5_byp", 0, 32'hDEADBEEF);
    cyc(); rd(0, 5);
    chk("r5_store", 0, 32'hDEADBEEF);
    chk("r5_err", 4, 32'h1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_rd0", 0, 32'h0);
    chk("async_busy", 3, 32'h0);
    chk("async_err", 4, 32'h0);
    -> chk_now;
    #1 reset = 1'b0;

    cyc(); iss(7); rd(0, 7);
    chk("iss7_lat", 2, 32'h0);
    cyc(); wr(0, 7, 32'h1234); rd(0, 7);
    chk("byp_rd0", 0, 32'h1234);
    chk("byp_rbusy", 2, 32'h0);
    chk("byp_bvec", 3, 32'h80);
    cyc(); rd(0, 7);
    chk("byp_store", 0, 32'h1234);
    chk("byp_clr", 3, 32'h0);
    chk("byp_err", 4, 32'h0);

    cyc(); wr(0, 0, 32'hFFFFFFFF); iss(0); rd(0, 0); rd(1, 0);
    chk("zr_byp", 0, 32'h0);
    chk("zr_byp1", 1, 32'h0);
    cyc(); rd(0, 0);
    chk("zr_rd", 0, 32'h0);
    chk("zr_busy", 3, 32'h0);
    chk("zr_err", 4, 32'h0);

    cyc(); iss(3); rd(0, 3);
    cyc(); rd(0, 3);
    chk("sb_busy", 2, 32'h1);
    chk("sb_vec", 3, 32'h8);
    cyc(); wr(0, 3, 32'h55); rd(0, 3);
    chk("sb_wr_busy", 2, 32'h0);
    chk("sb_wr_data", 0, 32'h55);
    cyc(); iss(3); rd(0, 3);
    chk("sb_clr", 3, 32'h0);
    cyc(); iss(3); wr(1, 3, 32'h66); rd(0, 3);
    chk("sb_set_rb", 2, 32'h0);
    cyc(); rd(0, 3);
    chk("sb_setwin", 3, 32'h8);
    chk("sb_setwin_rb", 2, 32'h1);
    chk("sb_r3", 0, 32'h66);
    chk("sb_err", 4, 32'h0);

    cyc(); iss(9);
    cyc(); wr(0, 9, 32'h99);
    cyc(); stall = 1'b1; wr(0, 9, 32'hAA); iss(10);
    rd(0, 9); rd(1, 10);
    chk("st_nobyp", 0, 32'h99);
    cyc(); rd(0, 9);
    chk("st_hold", 0, 32'h99);
    chk("st_noiss", 3, 32'h8);
    chk("st_err", 4, 32'h0);

    cyc(); iss(4);
    cyc(); wr(0, 4, 32'h11); wr(1, 4, 32'h22); rd(1, 4);
    chk("mp_byp", 1, 32'h22);
    cyc(); rd(1, 4);
    chk("mp_store", 1, 32'h22);
    chk("mp_err", 4, 32'h0);
    cyc(); wr(1, 6, 32'h66); rd(0, 6);
    chk("nb_byp", 0, 32'h66);
    chk("nb_err_pre", 4, 32'h0);
    cyc();
    chk("nb_err", 4, 32'h1);
    cyc();
    chk("nb_sticky", 4, 32'h1);
    cyc(); reset = 1'b1;
    chk("nb_rst", 4, 32'h0);
    cyc(); reset = 1'b0;

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
